// File: rtl/packet_switch_dbg_pkg.sv
// -----------------------------------------------------------------------------
// packet_switch_dbg_pkg
// Shared constants and types for the packet-switch debug counter bank:
// the CSR word/address widths, the CTRL register address and its action bits,
// and a helper that builds the identification word returned at CTRL_ADDR.
// -----------------------------------------------------------------------------
package packet_switch_dbg_pkg;

   localparam int CSR_DATA_W = 32;
   localparam int CSR_ADDR_W = 8;

   localparam logic [CSR_ADDR_W-1:0] CTRL_ADDR = '0;

   localparam int CTRL_SNAPSHOT_BIT = 0;
   localparam int CTRL_CLEAR_BIT    = 1;

   typedef logic [CSR_DATA_W-1:0] csr_word_t;

   // Identification word read back from CTRL_ADDR: counter count in bits [15:8].
   function automatic csr_word_t id_word(input int num_cntr);
      logic [7:0] n8;
      n8 = 8'(num_cntr);
      return {16'h0000, n8, 8'h00};
   endfunction

endpackage

// File: rtl/packet_switch_dbg_cntr.sv
// -----------------------------------------------------------------------------
// packet_switch_dbg_cntr
// Combinational increment stage for a bank of event counters. Each counter
// advances by one when its enable bit is set and wraps modulo 2^CNTR_WIDTH.
//
// Ports:
//   enable  in  [NUM_CNTR]             per-counter increment request
//   cntr_i  in  [NUM_CNTR][CNTR_WIDTH] current counter values
//   cntr_o  out [NUM_CNTR][CNTR_WIDTH] incremented counter values
// -----------------------------------------------------------------------------
module packet_switch_dbg_cntr
   import packet_switch_dbg_pkg::*;
#(
   parameter int CNTR_WIDTH = 32,
   parameter int NUM_CNTR   = 8
) (
   input  logic [NUM_CNTR-1:0]                 enable,
   input  logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_i,
   output logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_o
);

   always_comb begin
      for (int i = 0; i < NUM_CNTR; i++) begin
         cntr_o[i] = cntr_i[i] + CNTR_WIDTH'(enable[i]);
      end
   end

endmodule

// File: rtl/packet_switch_dbg_cntr_bank.sv
// -----------------------------------------------------------------------------
// packet_switch_dbg_cntr_bank
// Debug event counter bank for the packet switch. Event strobes are registered,
// then counted into live counters. A CTRL write can copy all live counters
// into a snapshot bank in one cycle and/or clear the live counters without
// losing an event arriving in the same cycle. Snapshot values are read over a
// simple CSR port with a fixed one-cycle read latency.
//
// Ports:
//   clk                in   clock
//   rst_n              in   asynchronous active-low reset
//   evt_i              in   [NUM_CNTR] per-counter event strobes
//   csr_write          in   write strobe
//   csr_read           in   read strobe
//   csr_address        in   [8] word address (0 = CTRL/ID, k = snapshot k-1)
//   csr_writedata      in   [32] write data (CTRL: bit0 SNAPSHOT, bit1 CLEAR)
//   csr_readdata       out  [32] read data, holds when not valid
//   csr_readdatavalid  out  one-cycle pulse qualifying csr_readdata
// -----------------------------------------------------------------------------
module packet_switch_dbg_cntr_bank
   import packet_switch_dbg_pkg::*;
#(
   parameter int CNTR_WIDTH = 32,
   parameter int NUM_CNTR   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CNTR-1:0]   evt_i,
   input  logic                  csr_write,
   input  logic                  csr_read,
   input  logic [CSR_ADDR_W-1:0] csr_address,
   input  logic [CSR_DATA_W-1:0] csr_writedata,
   output logic [CSR_DATA_W-1:0] csr_readdata,
   output logic                  csr_readdatavalid
);

   if (CNTR_WIDTH < 1 || CNTR_WIDTH > 32) begin : g_bad_width
      $error("packet_switch_dbg_cntr_bank: CNTR_WIDTH must be 1..32");
   end
   if (NUM_CNTR < 1 || NUM_CNTR > 255) begin : g_bad_num
      $error("packet_switch_dbg_cntr_bank: NUM_CNTR must be 1..255");
   end

   logic [NUM_CNTR-1:0]                 evt_q;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_q;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_d;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cntr_inc;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] snap_q;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] snap_d;
   csr_word_t                           rdata_q;
   csr_word_t                           rdata_d;
   logic                                rvalid_q;

   logic ctrl_wr;
   logic do_snap;
   logic do_clear;

   // Only bits 0 and 1 of a CTRL write carry meaning.
   logic unused_wdata;
   assign unused_wdata = ^csr_writedata[CSR_DATA_W-1:2];

   assign ctrl_wr  = csr_write && (csr_address == CTRL_ADDR);
   assign do_snap  = ctrl_wr && csr_writedata[CTRL_SNAPSHOT_BIT];
   assign do_clear = ctrl_wr && csr_writedata[CTRL_CLEAR_BIT];

   packet_switch_dbg_cntr #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .NUM_CNTR   (NUM_CNTR)
   ) u_inc (
      .enable (evt_q),
      .cntr_i (cntr_q),
      .cntr_o (cntr_inc)
   );

   // Clear restarts each counter at the event it is counting this cycle, so a
   // clear never drops an event and back-to-back SNAPSHOT|CLEAR intervals sum
   // exactly to the total event count.
   always_comb begin
      cntr_d = cntr_inc;
      if (do_clear) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            cntr_d[i] = CNTR_WIDTH'(evt_q[i]);
         end
      end
   end

   // Snapshot copies the pre-increment/pre-clear live values of every counter.
   assign snap_d = do_snap ? cntr_q : snap_q;

   // Read mux uses snap_q as registered before this edge, so a snapshot write
   // in the same cycle is not yet visible to the read.
   always_comb begin
      rdata_d = rdata_q;
      if (csr_read) begin
         rdata_d = '0;
         if (csr_address == CTRL_ADDR) begin
            rdata_d = id_word(NUM_CNTR);
         end else begin
            for (int i = 0; i < NUM_CNTR; i++) begin
               if (csr_address == CSR_ADDR_W'(i + 1)) begin
                  rdata_d = csr_word_t'(snap_q[i]);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q    <= '0;
         cntr_q   <= '0;
         snap_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         evt_q    <= evt_i;
         cntr_q   <= cntr_d;
         snap_q   <= snap_d;
         rdata_q  <= rdata_d;
         rvalid_q <= csr_read;
      end
   end

   assign csr_readdata      = rdata_q;
   assign csr_readdatavalid = rvalid_q;

endmodule

// File: doc/packet_switch_dbg_cntr_bank.md
# packet_switch_dbg_cntr_bank

Register bank for packet-switch debug event counters. Registers per-counter event pulses and holds the live counter state, using the combinational increment stage `packet_switch_dbg_cntr` for the +1 step. Provides a coherent snapshot copy and a clear operation, and serves reads over a simple CSR port. Sits between the switch datapath event strobes and the debug CSR interconnect.

## Interface
- `CNTR_WIDTH`, 32: counter width. Legal range 1..32; elaboration error outside it.
- `NUM_CNTR`, 8: number of counters. Legal range 1..255; elaboration error outside it.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `evt_i` in `NUM_CNTR`: per-counter event strobe, one increment per cycle it is high.
- `csr_write` in 1: write strobe.
- `csr_read` in 1: read strobe.
- `csr_address` in 8: word address.
- `csr_writedata` in 32: write data.
- `csr_readdata` out 32: read data.
- `csr_readdatavalid` out 1: one-cycle pulse qualifying `csr_readdata`.

## Operation
- Event stage: `evt_q <= evt_i` every cycle.
- Live counters:
  - `cntr <= inc(cntr, evt_q)`.
  - Wraps modulo 2^`CNTR_WIDTH`; no saturation, no overflow flag.
- CSR map:
  - Address 0 write is CTRL. Bit 0 = SNAPSHOT, bit 1 = CLEAR; other bits ignored. Bits are self-clearing actions, not stored.
  - Address 0 read returns `{16'h0, NUM_CNTR[7:0], 8'h00}`.
  - Address k (1..`NUM_CNTR`) read returns `snap[k-1]`, zero-extended to 32 bits.
  - Reads of addresses above `NUM_CNTR` return 0.
  - Writes to any nonzero address are ignored.
- SNAPSHOT: at the write edge, `snap[i] <= cntr[i]` for all i, in a single cycle, so all values come from the same instant.
- CLEAR: at the write edge, `cntr[i] <= evt_q[i] ? 1 : 0`. An event pending in the same cycle is counted, never lost.
- SNAPSHOT and CLEAR in the same write:
  - Snapshot captures the pre-clear values.
  - The clear rule above applies.
  - Result is lossless interval counting.
- Read and write in the same cycle:
  - Both are serviced.
  - The read returns `snap` as it was before the edge, i.e. the old snapshot.
- Back-to-back reads: one result per cycle, no stall. There is no waitrequest.
- Reset, asynchronous:
  - `evt_q`, `cntr`, `snap` = 0.
  - `csr_readdata` = 0, `csr_readdatavalid` = 0.
  - Reset mid-read: the pending `readdatavalid` is dropped.

## Timing
- Event latency:
  - `evt_i` sampled at edge N increments `cntr` at edge N+1.
  - A snapshot at edge S includes events sampled at edges ≤ S−2.
  - An event sampled at edge S−1 lands in `cntr` at edge S and is excluded from that snapshot.
- Read latency is 1:
  - `csr_read` sampled at edge R gives `csr_readdatavalid` = 1 and valid `csr_readdata` in the cycle after R, for exactly one cycle.
  - `csr_readdata` holds its last value when valid is low.
- Snapshot visibility: a snapshot write at edge S is visible to a read sampled at edge S+1 or later.

## Structure
- Package `packet_switch_dbg_pkg` holds:
  - `CSR_DATA_W` = 32.
  - `CSR_ADDR_W` = 8.
  - `CTRL_ADDR` = 0.
  - `CTRL_SNAPSHOT_BIT` = 0, `CTRL_CLEAR_BIT` = 1.
  - Typedef `csr_word_t`.
- Sub-module: one instance of `packet_switch_dbg_cntr`.
  - `NUM_CNTR`/`CNTR_WIDTH` passed through.
  - `enable` = `evt_q`, `cntr_i` = `cntr`, `cntr_o` = next value.
  - The bank muxes in the clear value ahead of the `cntr` registers.

## Test plan
- Reset, then pulse `evt_i[2]` for 5 cycles, SNAPSHOT, read address 3 → `0x5`. Other addresses read 0. Address 0 reads `0x0000_0800` with `NUM_CNTR`=8.
- `CNTR_WIDTH`=8: preload via 255 events on counter 0, add 2 more, snapshot → address 1 reads `0x01` (wrap).
- Hold `evt_i[0]` high continuously. Issue SNAPSHOT|CLEAR every 100 cycles. Every snapshot after the first reads exactly 100, proving no event is lost at clear.
- Event sampled at edge S−1, SNAPSHOT at edge S → snapshot excludes it. A second SNAPSHOT shows +1.
- Read addresses 1..8 back-to-back with a SNAPSHOT write in the same cycle as the first read:
  - The first read returns the old snapshot.
  - Later reads return the new snapshot.
  - `readdatavalid` is high for 8 consecutive cycles.
- Assert `rst_n` low for one cycle with a read outstanding and counters nonzero → `readdatavalid` stays 0, and all addresses read 0 after a fresh SNAPSHOT.
